host_interface_master: RTL and testbench

Host-side initiator for the FPGA host-interface (GPIF) protocol, i.e. the block that drives the FX2 end of the bus. It turns a command (endpoint, register, direction, word count) into the full phase sequence on state/ctl/data: set endpoint, set register, optional read terminal count, then the data phase. It serves as the bus driver for FPGA-to-FPGA bridging, and as the protocol master in the responder's system-level benches.

---
 rtl/host_interface_pkg.sv | 23 ++
 rtl/host_interface_master.sv | 199 +++++++++++++++++++
 tb/tb_host_interface_master.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_interface_pkg.sv
// Shared GPIF constants: bus state codes, master FSM encoding and ctl bit index.
// Imported by both the host-side master and the responder.
package host_interface_pkg;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] SETEP   = 4'd1;
    localparam logic [3:0] SETREG  = 4'd2;
    localparam logic [3:0] SETRVAL = 4'd3;
    localparam logic [3:0] RDDATA  = 4'd4;
    localparam logic [3:0] RDTC    = 4'd7;

    localparam int CTL_RDWR = 1;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_EP,
        FSM_REG,
        FSM_TC,
        FSM_XFER,
        FSM_FIN
    } fsm_t;

endpackage

// File: rtl/host_interface_master.sv
// GPIF host-side initiator: sequences SETEP, SETREG, optional RDTC and the data phase
// for one command, with a per-word inactivity timeout on the data phase.
module host_interface_master
    import host_interface_pkg::*;
#(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic        if_clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [15:0] cmd_ep,
    input  logic [15:0] cmd_reg,
    input  logic [15:0] cmd_len,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_accept,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        timeout_err,
    output logic [3:0]  gpif_state,
    output logic [2:0]  gpif_ctl,
    input  logic        gpif_rdy,
    output logic [15:0] gpif_data_out,
    output logic        gpif_data_oe,
    input  logic [15:0] gpif_data_in
);

    localparam int SW = $clog2(SETTLE + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_END   = SW'(SETTLE);
    localparam logic [SW-1:0] STROBE_END   = SW'(SETTLE + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    fsm_t          r_fsm;
    logic          r_is_read;
    logic [15:0]   r_reg_addr;
    logic [15:0]   r_len;
    logic [15:0]   r_remaining;
    logic [SW-1:0] r_settle;
    logic [TW-1:0] r_idle_cnt;
    logic          r_ctl_rdwr;
    logic          r_cmd_ready;
    logic          r_done;
    logic          r_timeout_err;
    logic          r_rd_valid;
    logic [15:0]   r_rd_data;
    logic [3:0]    r_gpif_state;
    logic [15:0]   r_data_out;
    logic          r_oe;

    logic       w_addr_phase;
    logic       w_addr_end;
    logic       w_xfer_active;
    logic       w_wr_accept;
    logic       w_rd_word;
    logic       w_word_moved;
    logic       w_timeout;
    logic       w_xfer_end;
    logic       w_skip_xfer;
    logic       w_enter_fin;
    logic [2:0] w_ctl;

    assign w_addr_phase  = (r_fsm == FSM_EP) || (r_fsm == FSM_REG) || (r_fsm == FSM_TC);
    assign w_addr_end    = w_addr_phase && (r_settle == STROBE_END);
    assign w_xfer_active = (r_fsm == FSM_XFER) && (r_settle == SETTLE_END);
    // Gated by reset so an abandoned burst never pops a word from the source.
    assign w_wr_accept   = !reset && w_xfer_active && !r_is_read && gpif_rdy && wr_valid
                           && (r_remaining != 16'd0);
    assign w_rd_word     = w_xfer_active && r_is_read && gpif_rdy && (r_remaining != 16'd0);
    assign w_word_moved  = w_wr_accept || w_rd_word;
    assign w_timeout     = w_xfer_active && !w_word_moved && (r_idle_cnt == TIMEOUT_LAST);
    // A write ends one cycle after its last strobe launches, a read on its last word.
    assign w_xfer_end    = w_xfer_active && (r_is_read ? (w_rd_word && r_remaining == 16'd1)
                                                       : (r_remaining == 16'd0));
    assign w_skip_xfer   = w_addr_end && (r_len == 16'd0)
                           && ((r_fsm == FSM_TC) || (r_fsm == FSM_REG && !r_is_read));
    assign w_enter_fin   = w_xfer_end || w_timeout || w_skip_xfer;

    always_ff @(posedge if_clock) begin
        if (reset) begin
            r_fsm         <= FSM_IDLE;
            r_is_read     <= 1'b0;
            r_reg_addr    <= '0;
            r_len         <= '0;
            r_remaining   <= '0;
            r_settle      <= '0;
            r_idle_cnt    <= '0;
            r_ctl_rdwr    <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_gpif_state  <= IDLE;
            r_data_out    <= '0;
            r_oe          <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_rd_valid    <= 1'b0;
            case (r_fsm)
                FSM_IDLE, FSM_FIN: begin
                    r_fsm <= FSM_IDLE;
                    if (cmd_valid && r_cmd_ready) begin
                        r_fsm        <= FSM_EP;
                        r_cmd_ready  <= 1'b0;
                        r_gpif_state <= SETEP;
                        r_data_out   <= cmd_ep;
                        r_oe         <= 1'b1;
                        r_settle     <= '0;
                        r_ctl_rdwr   <= 1'b0;
                        r_is_read    <= cmd_read;
                        r_reg_addr   <= cmd_reg;
                        r_len        <= cmd_len;
                    end
                end
                FSM_EP, FSM_REG, FSM_TC: begin
                    r_settle <= r_settle + SW'(1);
                    if (r_settle == SETTLE_END) begin
                        r_ctl_rdwr <= 1'b1;
                    end
                    if (w_addr_end) begin
                        r_ctl_rdwr <= 1'b0;
                        r_settle   <= '0;
                        if (r_fsm == FSM_EP) begin
                            r_fsm        <= FSM_REG;
                            r_gpif_state <= SETREG;
                            r_data_out   <= r_reg_addr;
                        end else if (r_fsm == FSM_REG && r_is_read) begin
                            r_fsm        <= FSM_TC;
                            r_gpif_state <= RDTC;
                            r_data_out   <= r_len;
                        end else begin
                            r_fsm        <= FSM_XFER;
                            r_gpif_state <= r_is_read ? RDDATA : SETRVAL;
                            r_oe         <= !r_is_read;
                            r_remaining  <= r_len;
                            r_idle_cnt   <= '0;
                        end
                    end
                end
                FSM_XFER: begin
                    if (r_settle != SETTLE_END) begin
                        r_settle <= r_settle + SW'(1);
                    end else begin
                        r_idle_cnt <= w_word_moved ? '0 : r_idle_cnt + TW'(1);
                        if (r_is_read) begin
                            r_ctl_rdwr <= (r_remaining != 16'd0)
                                          && !(w_rd_word && r_remaining == 16'd1);
                            if (w_rd_word) begin
                                r_rd_data   <= gpif_data_in;
                                r_rd_valid  <= 1'b1;
                                r_remaining <= r_remaining - 16'd1;
                            end
                        end else begin
                            r_ctl_rdwr <= w_wr_accept;
                            if (w_wr_accept) begin
                                r_data_out  <= wr_data;
                                r_remaining <= r_remaining - 16'd1;
                            end
                        end
                    end
                end
                default: r_fsm <= FSM_IDLE;
            endcase
            if (w_enter_fin) begin
                r_fsm         <= FSM_FIN;
                r_gpif_state  <= IDLE;
                r_ctl_rdwr    <= 1'b0;
                r_oe          <= 1'b0;
                r_remaining   <= '0;
                r_cmd_ready   <= 1'b1;
                r_done        <= 1'b1;
                r_timeout_err <= w_timeout && !w_xfer_end;
            end
        end
    end

    always_comb begin
        w_ctl           = '0;
        w_ctl[CTL_RDWR] = r_ctl_rdwr;
    end

    assign cmd_ready     = r_cmd_ready;
    assign wr_accept     = w_wr_accept;
    assign rd_data       = r_rd_data;
    assign rd_valid      = r_rd_valid;
    assign done          = r_done;
    assign timeout_err   = r_timeout_err;
    assign gpif_state    = r_gpif_state;
    assign gpif_ctl      = w_ctl;
    assign gpif_data_out = r_data_out;
    assign gpif_data_oe  = r_oe;

endmodule

// File: tb/tb_host_interface_master.sv
// Scoreboard bench for host_interface_master: stimulus queues expected bus events,
// a negedge monitor pops and compares strobes, read words and done pulses.
module tb_host_interface_master;
    import host_interface_pkg::*;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 16;
    localparam int K_STROBE = 0;
    localparam int K_RD     = 1;
    localparam int K_DONE   = 2;

    typedef struct {
        int          kind;
        logic [3:0]  st;
        logic [15:0] data;
    } ev_t;

    logic        if_clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_read = 1'b0;
    logic [15:0] cmd_ep = '0;
    logic [15:0] cmd_reg = '0;
    logic [15:0] cmd_len = '0;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        gpif_rdy = 1'b0;
    logic [15:0] gpif_data_in = '0;
    logic        cmd_ready;
    logic        wr_accept;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        timeout_err;
    logic [3:0]  gpif_state;
    logic [2:0]  gpif_ctl;
    logic [15:0] gpif_data_out;
    logic        gpif_data_oe;

    host_interface_master #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .if_clock      (if_clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_read      (cmd_read),
        .cmd_ep        (cmd_ep),
        .cmd_reg       (cmd_reg),
        .cmd_len       (cmd_len),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_accept     (wr_accept),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .done          (done),
        .timeout_err   (timeout_err),
        .gpif_state    (gpif_state),
        .gpif_ctl      (gpif_ctl),
        .gpif_rdy      (gpif_rdy),
        .gpif_data_out (gpif_data_out),
        .gpif_data_oe  (gpif_data_oe),
        .gpif_data_in  (gpif_data_in)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    ev_t exp_q[$];
    logic [15:0] wr_q[$];
    logic [15:0] resp_q[$];
    bit wr_en = 1'b1;
    bit rdy_wr = 1'b1;
    bit rdy_stuck = 1'b0;
    int wr_acc_count = 0;
    int rddata_cycles = 0;
    int setrval_cycles = 0;
    int setrval_strobes = 0;
    int done_count = 0;
    int rdv_count = 0;
    int done_cycles[$];
    int last_acc_cycle = -1;

    initial forever #5 if_clock = ~if_clock;
    initial forever begin
        @(posedge if_clock);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic expect_ev(input string name, input int kind, input logic [3:0] st,
                             input logic [15:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected event st=%0h data=%h expected none (cycle %0d)",
                     name, st, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.st !== st || e.data !== data) begin
                failures++;
                $display("FAIL %s got kind=%0d st=%0h data=%h expected kind=%0d st=%0h data=%h (cycle %0d)",
                         name, kind, st, data, e.kind, e.st, e.data, cyc);
            end
        end
    endtask

    function automatic void push_ev(input int kind, input logic [3:0] st, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.st   = st;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Monitor: one pass per cycle, sampled on the falling edge.
    initial begin
        logic [3:0] prev_state;
        bit prev_acc;
        prev_state = IDLE;
        prev_acc = 1'b0;
        forever begin
            @(negedge if_clock);
            if (reset) begin
                prev_state = IDLE;
                prev_acc = 1'b0;
                continue;
            end
            if (wr_accept) begin
                wr_acc_count++;
                check("accept_qualified", {30'd0, wr_valid, gpif_rdy}, 32'd3);
            end
            if (gpif_state == RDDATA) begin
                rddata_cycles++;
                check("oe_low_in_rddata", gpif_data_oe, 0);
            end
            if (gpif_state == SETRVAL) setrval_cycles++;
            if (gpif_state != prev_state) check("ctl_low_on_state_change", gpif_ctl[CTL_RDWR], 0);
            check("ctl_unused_bits", {gpif_ctl[2], gpif_ctl[0]}, 0);
            if (gpif_ctl[CTL_RDWR] && gpif_state != RDDATA) begin
                if (gpif_state == SETRVAL) begin
                    setrval_strobes++;
                    check("strobe_follows_accept", prev_acc, 1);
                end
                expect_ev("strobe", K_STROBE, gpif_state, gpif_data_out);
            end
            if (rd_valid) begin
                rdv_count++;
                expect_ev("rd_word", K_RD, IDLE, rd_data);
            end
            if (done) begin
                done_count++;
                done_cycles.push_back(cyc);
                check("done_state_idle", gpif_state, IDLE);
                check("done_cmd_ready", cmd_ready, 1);
                expect_ev("done", K_DONE, IDLE, {15'd0, timeout_err});
            end
            prev_state = gpif_state;
            prev_acc = wr_accept;
        end
    end

    // Word source and responder model; inputs change 1 time unit after the rising edge.
    initial begin
        bit acc;
        int age;
        age = 0;
        forever begin
            @(negedge if_clock);
            acc = wr_accept;
            @(posedge if_clock);
            #1;
            if (acc && wr_q.size() > 0) wr_q.delete(0);
            if (rd_valid && resp_q.size() > 0) resp_q.delete(0);
            if (gpif_state == RDDATA && gpif_ctl[CTL_RDWR]) age++;
            else age = 0;
            wr_valid = wr_en && (wr_q.size() > 0);
            wr_data  = (wr_q.size() > 0) ? wr_q[0] : 16'h0000;
            if (gpif_state == RDDATA) begin
                gpif_rdy     = !rdy_stuck && (age >= 3) && (resp_q.size() > 0);
                gpif_data_in = (resp_q.size() > 0) ? resp_q[0] : 16'h0000;
            end else begin
                gpif_rdy     = rdy_wr;
                gpif_data_in = 16'h0000;
            end
        end
    end

    task automatic start_cmd(input bit rd, input logic [15:0] ep, input logic [15:0] rg,
                             input logic [15:0] len, input logic [15:0] words[$], input bit err);
        int n;
        bit ok;
        push_ev(K_STROBE, SETEP, ep);
        push_ev(K_STROBE, SETREG, rg);
        if (rd) push_ev(K_STROBE, RDTC, len);
        foreach (words[i]) begin
            if (rd) begin
                push_ev(K_RD, IDLE, words[i]);
                resp_q.push_back(words[i]);
            end else begin
                push_ev(K_STROBE, SETRVAL, words[i]);
                wr_q.push_back(words[i]);
            end
        end
        push_ev(K_DONE, IDLE, {15'd0, err});
        n = 0;
        ok = 1'b0;
        cmd_read = rd; cmd_ep = ep; cmd_reg = rg; cmd_len = len; cmd_valid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge if_clock);
            if (cmd_ready) begin
                ok = 1'b1;
                last_acc_cycle = cyc;
            end
            @(posedge if_clock);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", ok, 1);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_count < target && n < 400) begin
            @(posedge if_clock);
            #1;
            n++;
        end
        check("done_within_budget", done_count, target);
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (wr_acc_count < target && n < 200) begin
            @(posedge if_clock);
            #1;
            n++;
        end
        check("accepts_within_budget", wr_acc_count >= target, 1);
    endtask

    initial begin
        logic [15:0] w[$];
        int base;
        int acc2;
        int n;

        repeat (3) @(posedge if_clock);
        #1;
        check("rst_state", gpif_state, 0);
        check("rst_ctl", gpif_ctl, 0);
        check("rst_data_out", gpif_data_out, 0);
        check("rst_oe", gpif_data_oe, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done", done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_wr_accept", wr_accept, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        repeat (2) @(posedge if_clock);
        #1;

        // Plain write, rdy tied high.
        base = done_count; wr_acc_count = 0;
        w = '{16'hBEEF, 16'h1234};
        start_cmd(1'b0, 16'h0003, 16'h0010, 16'd2, w, 1'b0);
        wait_done(base + 1);
        check("write_accepts", wr_acc_count, 2);
        $display("write ep=0003 reg=0010 len=2 accepts=%0d", wr_acc_count);

        // Read against the responder model.
        base = done_count; rdv_count = 0;
        w = '{16'h00A0, 16'h00A1, 16'h00A2};
        start_cmd(1'b1, 16'h0001, 16'h0020, 16'd3, w, 1'b0);
        wait_done(base + 1);
        check("read_word_count", rdv_count, 3);
        $display("read ep=0001 reg=0020 len=3 words=%0d", rdv_count);

        // Write with source and ready gaps mid-burst.
        base = done_count; wr_acc_count = 0;
        w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        start_cmd(1'b0, 16'h0005, 16'h0011, 16'd6, w, 1'b0);
        wait_acc(2);
        wr_en = 1'b0;
        repeat (5) @(posedge if_clock);
        #1;
        wr_en = 1'b1;
        wait_acc(4);
        rdy_wr = 1'b0;
        repeat (3) @(posedge if_clock);
        #1;
        rdy_wr = 1'b1;
        wait_done(base + 1);
        check("backpressure_accepts", wr_acc_count, 6);
        $display("write backpressure len=6 accepts=%0d", wr_acc_count);

        // Read timeout with rdy stuck low.
        base = done_count; rddata_cycles = 0; rdy_stuck = 1'b1;
        w.delete();
        start_cmd(1'b1, 16'h0004, 16'h0050, 16'd4, w, 1'b1);
        wait_done(base + 1);
        rdy_stuck = 1'b0;
        check("timeout_rddata_cycles", rddata_cycles, SETTLE + TIMEOUT);
        $display("read timeout len=4 rddata_cycles=%0d", rddata_cycles);

        // Zero-length write followed immediately by a read.
        base = done_count; setrval_cycles = 0;
        w.delete();
        start_cmd(1'b0, 16'h0007, 16'h0030, 16'd0, w, 1'b0);
        w = '{16'h0055};
        start_cmd(1'b1, 16'h0002, 16'h0040, 16'd1, w, 1'b0);
        acc2 = last_acc_cycle;
        wait_done(base + 2);
        check("zero_len_no_setrval", setrval_cycles, 0);
        if (done_cycles.size() > base) check("b2b_accept_in_done_cycle", acc2, done_cycles[base]);
        else check("b2b_first_done_seen", done_cycles.size(), base + 1);
        $display("zero-length write then read, second accepted at cycle %0d", acc2);

        // Reset in the second cycle of a write burst.
        base = done_count; setrval_strobes = 0;
        w = '{16'hD001, 16'hD002, 16'hD003, 16'hD004};
        start_cmd(1'b0, 16'h0008, 16'h0060, 16'd4, w, 1'b0);
        n = 0;
        while (setrval_strobes < 1 && n < 200) begin
            @(posedge if_clock);
            #1;
            n++;
        end
        check("burst_started", setrval_strobes >= 1, 1);
        reset = 1'b1;
        @(posedge if_clock);
        #1;
        exp_q.delete();
        wr_q.delete();
        check("mid_rst_state", gpif_state, 0);
        check("mid_rst_ctl", gpif_ctl, 0);
        check("mid_rst_oe", gpif_data_oe, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_done", done, 0);
        reset = 1'b0;
        repeat (10) @(posedge if_clock);
        #1;
        check("no_done_after_reset", done_count, base);
        w = '{16'hCAFE};
        start_cmd(1'b0, 16'h0009, 16'h0070, 16'd1, w, 1'b0);
        wait_done(base + 1);
        $display("reset mid-burst then write len=1 done_count=%0d", done_count);

        repeat (3) @(posedge if_clock);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
